// File: rtl/spi_master_fifo.sv
// spi_master_fifo: first-word-fall-through FIFO for the SPI master TX/RX paths.
// Ports: HCLK/HRESETn, clr_i, data_i/valid_i/ready_o (push side),
//   data_o/valid_o/ready_i (pop side), elements_o fill level,
//   th_i/th_hit_o threshold, ovf_o/udf_o sticky error flags.
module spi_master_fifo #(
  parameter int DATA_WIDTH       = 32,
  parameter int BUFFER_DEPTH     = 10,
  parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        clr_i,
  input  logic [DATA_WIDTH-1:0]       data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [LOG_BUFFER_DEPTH:0]   elements_o,
  input  logic [LOG_BUFFER_DEPTH:0]   th_i,
  output logic                        th_hit_o,
  output logic                        ovf_o,
  output logic                        udf_o
);

  localparam int PW = LOG_BUFFER_DEPTH;
  localparam int CW = LOG_BUFFER_DEPTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUFFER_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(BUFFER_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  ovf;
  logic                  udf;
  logic                  push;
  logic                  pop;
  logic [PW-1:0]         wr_nxt;
  logic [PW-1:0]         rd_nxt;

  // Handshake flags depend only on count, so no input-to-output path.
  assign ready_o    = (count != DEPTH_C);
  assign valid_o    = (count != '0);
  assign data_o     = mem[rd_ptr];
  assign elements_o = count;
  assign th_hit_o   = (th_i != '0) && (count >= th_i);
  assign ovf_o      = ovf;
  assign udf_o      = udf;

  assign push = valid_i & ready_o;
  assign pop  = ready_i & valid_o;

  // Depth need not be a power of two, so wrap explicitly.
  assign wr_nxt = (wr_ptr == LAST_C) ? '0 : wr_ptr + PW'(1);
  assign rd_nxt = (rd_ptr == LAST_C) ? '0 : rd_ptr + PW'(1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_nxt;
      if (pop)  rd_ptr <= rd_nxt;
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (valid_i && !ready_o) ovf <= 1'b1;
      if (ready_i && !valid_o) udf <= 1'b1;
    end
  end

  // Storage is left unreset; clear only gates the write.
  always_ff @(posedge HCLK) begin
    if (push && !clr_i) mem[wr_ptr] <= data_i;
  end

endmodule

// File: tb/tb_spi_master_fifo.sv
// tb_spi_master_fifo: scoreboard bench for spi_master_fifo.
// Stimulus queues expected words; a negedge monitor checks every pop.
module tb_spi_master_fifo;

  localparam int DW = 32;
  localparam int D  = 10;
  localparam int LW = $clog2(D);

  logic          HCLK;
  logic          HRESETn;
  logic          clr_i;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic [LW:0]   elements_o;
  logic [LW:0]   th_i;
  logic          th_hit_o;
  logic          ovf_o;
  logic          udf_o;

  int n_run;
  int n_fail;
  int mcnt;
  logic [DW-1:0] exp_q [$];

  spi_master_fifo #(
    .DATA_WIDTH(DW),
    .BUFFER_DEPTH(D),
    .LOG_BUFFER_DEPTH(LW)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .clr_i(clr_i),
    .data_i(data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .elements_o(elements_o),
    .th_i(th_i),
    .th_hit_o(th_hit_o),
    .ovf_o(ovf_o),
    .udf_o(udf_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: a pop is sampled at the next rising edge, so check mid-cycle.
  always @(negedge HCLK) begin
    if (HRESETn && !clr_i && valid_o && ready_i) begin
      n_run++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected none", data_o);
      end else begin
        automatic logic [DW-1:0] e = exp_q.pop_front();
        if (data_o !== e) begin
          n_fail++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", data_o, e);
        end
      end
    end
  end

  // One clock of stimulus; the expected-queue tracks accepted pushes.
  task automatic cyc(input bit do_push, input logic [DW-1:0] d,
                     input bit do_pop);
    bit acc;
    bit pv;
    acc = do_push && (mcnt != D);
    pv  = do_pop && (mcnt != 0);
    valid_i = do_push;
    data_i  = d;
    ready_i = do_pop;
    if (acc) exp_q.push_back(d);
    mcnt = mcnt + (acc ? 1 : 0) - (pv ? 1 : 0);
    @(posedge HCLK);
    #1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
  endtask

  task automatic do_clr();
    clr_i = 1'b1;
    @(posedge HCLK);
    #1;
    clr_i = 1'b0;
    exp_q.delete();
    mcnt = 0;
  endtask

  logic [DW-1:0] dv;
  int mx;

  initial begin
    n_run = 0;
    n_fail = 0;
    mcnt = 0;
    HRESETn = 1'b0;
    clr_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i = '0;
    th_i = '0;
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_elems", elements_o, 0);
    check("rst_th", th_hit_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_udf", udf_o, 0);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Fill then drain
    for (int i = 1; i <= 10; i++) cyc(1, i, 0);
    check("full_ready", ready_o, 0);
    check("full_elems", elements_o, 10);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1);
    check("drain_valid", valid_o, 0);
    check("drain_ovf", ovf_o, 0);
    check("drain_udf", udf_o, 0);
    check("drain_ready", ready_o, 1);

    // Wrap-around across pointer 9->0
    dv = 32'h100;
    mx = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 7; i++) begin
        cyc(1, dv, 0);
        dv++;
        if (int'(elements_o) > mx) mx = int'(elements_o);
      end
      check("wrap_elems7", elements_o, 7);
      for (int i = 0; i < 7; i++) cyc(0, 0, 1);
    end
    check("wrap_max", mx, 7);
    check("wrap_empty", elements_o, 0);

    // Simultaneous push/pop at count 5
    for (int i = 0; i < 5; i++) begin
      cyc(1, dv, 0);
      dv++;
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1, dv, 1);
      dv++;
      if (elements_o != 5) check("sim_elems_step", elements_o, 5);
    end
    check("sim_elems", elements_o, 5);
    check("sim_ovf", ovf_o, 0);
    check("sim_udf", udf_o, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1);

    // Overflow, then underflow
    for (int i = 0; i < 10; i++) cyc(1, 32'hA0 + i, 0);
    cyc(1, 32'hDEAD, 0);
    check("ovf_set", ovf_o, 1);
    check("ovf_elems", elements_o, 10);
    check("ovf_head", data_o, 32'hA0);
    do_clr();
    check("clr_ovf", ovf_o, 0);
    cyc(0, 0, 1);
    check("udf_set", udf_o, 1);
    check("udf_elems", elements_o, 0);
    do_clr();

    // Threshold
    th_i = 4;
    for (int i = 0; i < 3; i++) cyc(1, 32'hB0 + i, 0);
    check("th_below", th_hit_o, 0);
    cyc(1, 32'hB3, 0);
    check("th_hit", th_hit_o, 1);
    th_i = 0;
    #1;
    check("th_dis", th_hit_o, 0);
    th_i = 11;
    for (int i = 0; i < 6; i++) cyc(1, 32'hB4 + i, 0);
    check("th_over_depth", th_hit_o, 0);
    th_i = 0;
    do_clr();

    // Clear with concurrent push at count 6
    for (int i = 0; i < 6; i++) cyc(1, 32'hC0 + i, 0);
    clr_i = 1'b1;
    valid_i = 1'b1;
    data_i = 32'hC6;
    @(posedge HCLK);
    #1;
    clr_i = 1'b0;
    valid_i = 1'b0;
    exp_q.delete();
    mcnt = 0;
    check("clrp_elems", elements_o, 0);
    check("clrp_valid", valid_o, 0);
    check("clrp_ovf", ovf_o, 0);
    check("clrp_udf", udf_o, 0);
    cyc(1, 32'hC7, 0);
    check("clrp_head", data_o, 32'hC7);
    cyc(0, 0, 1);

    // Async reset mid-stream
    for (int i = 0; i < 3; i++) cyc(1, 32'hD0 + i, 0);
    #2;
    HRESETn = 1'b0;
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_elems", elements_o, 0);
    check("arst_ready", ready_o, 1);
    exp_q.delete();
    mcnt = 0;
    @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    cyc(1, 32'hE0, 0);
    check("post_rst_head", data_o, 32'hE0);
    cyc(0, 0, 1);

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master_fifo.md
# spi_master_fifo

Synchronous first-word-fall-through FIFO between the SPI master's APB register interface and its shift engine. One instance buffers TX words (APB TXFIFO writes → shift engine), a second buffers RX words (shift engine → APB RXFIFO reads). It supplies the fill level used for the TX/RX interrupt thresholds, plus sticky overflow/underflow flags for the interrupt status word.

## Interface
- DATA_WIDTH, 32, word width.
- BUFFER_DEPTH, 10, number of entries; any integer ≥ 2, not restricted to powers of two.
- LOG_BUFFER_DEPTH, ceil(log2(BUFFER_DEPTH)) (4 for 10), pointer width; count width is LOG_BUFFER_DEPTH+1.

Ports:
- HCLK  in  1  clock, all state on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- clr_i  in  1  synchronous clear (driven by spi_swrst).
- data_i  in  DATA_WIDTH  push data.
- valid_i  in  1  push request.
- ready_o  out  1  FIFO can accept a word.
- data_o  out  DATA_WIDTH  head-of-FIFO word.
- valid_o  out  1  head word valid.
- ready_i  in  1  consumer takes head word.
- elements_o  out  LOG_BUFFER_DEPTH+1  current fill level, 0..BUFFER_DEPTH.
- th_i  in  LOG_BUFFER_DEPTH+1  interrupt threshold (spi_int_th_tx / spi_int_th_rx).
- th_hit_o  out  1  threshold reached.
- ovf_o  out  1  sticky overflow.
- udf_o  out  1  sticky underflow.

## Operation
- State: wr_ptr, rd_ptr (LOG_BUFFER_DEPTH bits), count (LOG_BUFFER_DEPTH+1 bits), ovf, udf registers, plus BUFFER_DEPTH×DATA_WIDTH storage. Storage is not reset.
- ready_o = (count != BUFFER_DEPTH). It depends on count only, never on ready_i: a full FIFO does not accept a push even when a pop happens in the same cycle.
- valid_o = (count != 0). data_o = mem[rd_ptr], combinational. data_o is don't-care when valid_o = 0.
- push = valid_i & ready_o: write mem[wr_ptr] <= data_i and advance wr_ptr.
- pop = ready_i & valid_o: advance rd_ptr.
- Pointer advance: if the pointer equals BUFFER_DEPTH-1 it wraps to 0, otherwise it increments by 1. Never a modulo-2^n wrap.
- count: push only → +1; pop only → −1; push and pop together → unchanged, both pointers advance.
- elements_o = count.
- th_hit_o = (th_i != 0) & (count >= th_i), combinational. th_i = 0 disables it. th_i > BUFFER_DEPTH is never hit.
- ovf_o sets when valid_i & ~ready_o (push attempted while full). udf_o sets when ready_i & ~valid_o (pop attempted while empty). Both stay set until clr_i or reset. A rejected push and a rejected pop do not alter pointers, count or storage.
- clr_i = 1: next edge sets wr_ptr, rd_ptr, count, ovf and udf to 0. clr_i takes priority over a push, pop, ovf or udf event in the same cycle; those events are discarded.

## Timing
- Reset (HRESETn = 0, asynchronous): pointers, count, ovf_o and udf_o go to 0. Outputs during reset: ready_o = 1, valid_o = 0, elements_o = 0, th_hit_o = 0. Reset asserted mid-transfer discards all contents immediately.
- Push-to-read latency is 1 cycle. A word pushed at edge N is on data_o with valid_o = 1 after edge N. It can be popped in the cycle following edge N.
- Pop takes effect at the edge where ready_i & valid_o is sampled. The next word appears on data_o after that edge.
- ready_o deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the first pop from full.
- Full throughput: one push and one pop per cycle are sustained indefinitely at any fill level 1..BUFFER_DEPTH-1.
- The APB side delivers push/pop strobes for exactly one cycle (PSEL & PENABLE). No combinational path exists from valid_i to valid_o or from ready_i to ready_o.

## Test plan
- Fill then drain, BUFFER_DEPTH=10: push 0x00000001..0x0000000A on consecutive cycles → ready_o = 0 after the 10th push, elements_o = 10. Pop all 10 → data order 1..10, valid_o = 0 after the last pop, ovf_o = 0, udf_o = 0.
- Wrap-around: repeat 3 × (push 7, pop 7) with incrementing data → every word returned in order across the 9→0 pointer wrap. elements_o never exceeds 7.
- Simultaneous push/pop at count 5 for 20 cycles → elements_o stays 5, data order preserved, no flags set.
- Overflow/underflow: push an 11th word while full → ovf_o = 1, elements_o stays 10, head word unchanged. Clear, then pop while empty → udf_o = 1, count stays 0.
- Threshold: th_i = 4, push 3 words → th_hit_o = 0. Push 4th → th_hit_o = 1. Set th_i = 0 → th_hit_o = 0.
- clr_i with a concurrent push at count 6 → next cycle count = 0, valid_o = 0, flags 0, pushed word dropped. Async HRESETn pulse mid-stream → outputs take their reset values immediately.
